// File: rtl/clz_normalizer_if.sv
// Request/result bundle for the leading-zero/one counter and normalizer.
interface clz_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] i_data;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] o_norm;

  // Requester side: issues operations, observes handshake and results.
  modport master (
    output start, op, i_data,
    input  busy, done, count, o_norm
  );

  // Counter side: accepts operations, produces handshake and results.
  modport slave (
    input  start, op, i_data,
    output busy, done, count, o_norm
  );
endinterface

// File: rtl/clz_normalizer.sv
// Iterative CLZ/CLO counter and normalizer: one bit position per clock.
// Returns the leading-bit count and the operand left-shifted by that count.
module clz_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  clz_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             tgt_q,   tgt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] norm_q,  norm_d;

  // State, working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      count_q <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
      norm_q  <= norm_d;
    end
  end

  // Next-state: accept in IDLE/DONE, shift-and-count in RUN.
  // Saturation at WIDTH is checked before the bit test so an all-target
  // operand stops without an extra shift.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    count_d = count_q;
    norm_d  = norm_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          shreg_d = bus.i_data;
          tgt_d   = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ((cnt_q == FULL) || (shreg_q[WIDTH-1] != tgt_q)) begin
          count_d = cnt_q;
          norm_d  = shreg_q;
          state_d = DONE;
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.count  = count_q;
  assign bus.o_norm = norm_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Self-checking bench for clz_normalizer: directed plan vectors plus
// randomized operands against a leading-bit reference model.
module tb_clz_normalizer;
  localparam int W   = 32;
  localparam int CWL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  clz_normalizer_if #(.WIDTH(W), .CW(CWL)) bus ();

  clz_normalizer #(.WIDTH(W), .CW(CWL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: walk from the MSB while bits equal the target.
  function automatic void model(input logic [W-1:0] d, input logic o,
                                output int n, output logic [W-1:0] nm);
    n = 0;
    while (n < W && d[W-1-n] == o) n++;
    if (n >= W) nm = '0;
    else        nm = d << n;
  endfunction

  // Present a request now, let the next rising edge take it, then drop start.
  task automatic issue(input logic [W-1:0] d, input logic o);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.i_data = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called right after issue(); edges counted from the accepting edge.
  task automatic wait_done(output int edges, output int bcyc, output logic busy_at_done);
    edges = -1;
    bcyc = bus.busy ? 1 : 0;
    busy_at_done = 1'b1;
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = k;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.o_norm !== '0) begin failures++; $display("FAIL reset_norm got=%h exp=0", bus.o_norm); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0] vd [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFF0_1234};
    logic         vo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int           vn [4] = '{0, 31, 32, 12};
    logic [W-1:0] vm [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0123_4000};
    int edges, bcyc;
    logic bad;
    for (int i = 0; i < 4; i++) begin
      issue(vd[i], vo[i]);
      wait_done(edges, bcyc, bad);
      checks++; if (bus.count !== CWL'(vn[i])) begin failures++; $display("FAIL dir%0d_count got=%0d exp=%0d", i, bus.count, vn[i]); end
      checks++; if (bus.o_norm !== vm[i]) begin failures++; $display("FAIL dir%0d_norm got=%h exp=%h", i, bus.o_norm, vm[i]); end
      checks++; if (edges != vn[i] + 1) begin failures++; $display("FAIL dir%0d_latency done_after_edge got=%0d exp=%0d", i, edges, vn[i] + 1); end
      checks++; if (bcyc != vn[i] + 1) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcyc, vn[i] + 1); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_in_done got=%0b exp=0", i, bad); end
      @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_width got=%0b exp=0", i, bus.done); end
    end
  endtask

  task automatic test_back_to_back();
    int edges, bcyc;
    logic bad;
    issue(32'hFFF0_1234, 1'b1);
    wait_done(edges, bcyc, bad);
    checks++; if (bus.count !== 6'd12) begin failures++; $display("FAIL b2b_first_count got=%0d exp=12", bus.count); end
    // Still inside the DONE cycle: issue the next one with no gap.
    issue(32'hFFFF_FFFF, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap busy got=%0b exp=1", bus.busy); end
    wait_done(edges, bcyc, bad);
    checks++; if (bus.count !== 6'd32) begin failures++; $display("FAIL b2b_count got=%0d exp=32", bus.count); end
    checks++; if (bus.o_norm !== '0) begin failures++; $display("FAIL b2b_norm got=%h exp=0", bus.o_norm); end
    checks++; if (edges != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", edges); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int edges = -1;
    issue(32'h0001_0000, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin bus.start = 1'b1; bus.op = 1'b1; bus.i_data = 32'hFFFF_FFFF; end
      if (k == 6) bus.start = 1'b0;
      if (bus.done) begin pulses++; if (edges < 0) edges = k; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    checks++; if (edges != 16) begin failures++; $display("FAIL ign_latency got=%0d exp=16", edges); end
    checks++; if (bus.count !== 6'd15) begin failures++; $display("FAIL ign_count got=%0d exp=15", bus.count); end
    checks++; if (bus.o_norm !== 32'h8000_0000) begin failures++; $display("FAIL ign_norm got=%h exp=80000000", bus.o_norm); end
  endtask

  task automatic test_abort();
    int edges, bcyc;
    logic bad;
    logic seen = 1'b0;
    issue(32'h0000_00FF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", bus.done); end
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL abort_count got=%0d exp=0", bus.count); end
    checks++; if (bus.o_norm !== '0) begin failures++; $display("FAIL abort_norm got=%h exp=0", bus.o_norm); end
    repeat (3) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got=%0b exp=0", seen); end
    issue(32'h0000_00FF, 1'b0);
    wait_done(edges, bcyc, bad);
    checks++; if (bus.count !== 6'd24) begin failures++; $display("FAIL abort_rerun_count got=%0d exp=24", bus.count); end
    checks++; if (bus.o_norm !== 32'hFF00_0000) begin failures++; $display("FAIL abort_rerun_norm got=%h exp=ff000000", bus.o_norm); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int edges, bcyc, n, lead;
    logic bad, o;
    logic [W-1:0] d, mask, nm;
    for (int i = 0; i < 30; i++) begin
      lead = $urandom_range(0, W);
      o    = 1'($urandom_range(0, 1));
      d    = $urandom;
      mask = (lead >= W) ? '1 : ~({W{1'b1}} >> lead);
      d    = o ? (d | mask) : (d & ~mask);
      model(d, o, n, nm);
      issue(d, o);
      wait_done(edges, bcyc, bad);
      checks++; if (bus.count !== CWL'(n)) begin failures++; $display("FAIL rnd%0d_count d=%h op=%0b got=%0d exp=%0d", i, d, o, bus.count, n); end
      checks++; if (bus.o_norm !== nm) begin failures++; $display("FAIL rnd%0d_norm d=%h op=%0b got=%h exp=%h", i, d, o, bus.o_norm, nm); end
      checks++; if (edges != n + 1) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, edges, n + 1); end
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.i_data = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clz_normalizer.md
Name: clz_normalizer

Overview:
- Multi-cycle leading-zero/leading-one counter and normalizer for the MIPS datapath. It backs the CLZ/CLO instructions and supplies normalization shift amounts.
- It is the inverse of the shift path. The shifter takes data plus a shift amount and returns shifted data; this block takes data and returns the shift amount plus the normalized (left-shifted) data.
- It works iteratively, one bit position per clock, under a start/busy/done handshake. The control unit stalls on busy.

Parameters:
- WIDTH, 32: data width. Must be a power of two, ≥ 2.
- CW, 6: count width. Equals log2(WIDTH)+1, so the count can hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only while busy=0.
- op  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO). Captured with start.
- i_data  input  WIDTH  operand. Captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- count  output  CW  number of leading bits equal to the target bit, 0..WIDTH.
- o_norm  output  WIDTH  i_data << count, zero-filled. Equals 0 when count=WIDTH.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, count=0, o_norm=0; internal shift register and counter cleared.
- Release of rst_n is synchronous to clk. The first start is accepted on the first rising edge after release.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load shift register ← i_data, target ← op, counter ← 0, go to RUN.
  - busy=1 from the cycle after that edge.
- RUN, evaluated each edge:
  - If counter==WIDTH or shreg[WIDTH-1] != target: stop, go to DONE.
  - Otherwise: shreg ← shreg<<1 (LSB filled with 0), counter ← counter+1, stay in RUN.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - count and o_norm take their final values on entry.
  - On the next edge: if start=1, behave as IDLE+start (back-to-back issue with no gap); otherwise go to IDLE.
- Latency: for result N, RUN lasts N+1 cycles. With the start-sampling edge as edge 0, done is high in the cycle after edge N+1, i.e. sampled high at edge N+2. Range: 2 cycles (N=0) to WIDTH+2 cycles (N=WIDTH).
- count and o_norm are registered and update only on DONE entry. They hold their values through IDLE until the next DONE, so they stay stable while busy.
- start while busy=1 is ignored. i_data and op are not re-sampled mid-operation.
- Zero / all-ones operand: the counter saturates at WIDTH. The check counter==WIDTH takes priority over the bit test, so no extra shift occurs and no wrap happens.
- No arithmetic overflow: counter width is CW, and the maximum value is WIDTH < 2^CW.
- rst_n asserted in RUN or DONE: abort immediately to the reset values; no done pulse is produced.
- A start held high continuously issues a new operation on every edge where busy=0.

Test Plan:
- CLZ, i_data=0x8000_0000 → count=0, o_norm=0x8000_0000; done sampled at edge 2; busy high only during the 1 RUN cycle.
- CLZ, i_data=0x0000_0001 → count=31, o_norm=0x8000_0000; done at edge 33.
- CLZ, i_data=0x0000_0000 → count=32, o_norm=0x0000_0000; done at edge 34; no wrap of count.
- CLO, i_data=0xFFF0_1234 → count=12, o_norm=0x0123_4000. Then CLO 0xFFFF_FFFF issued in the DONE cycle → accepted with no idle gap; count=32, o_norm=0.
- CLZ 0x0001_0000 started, then start=1 with op=1 and i_data=0xFFFF_FFFF pulsed mid-RUN → ignored; result count=15, o_norm=0x8000_0000; exactly one done pulse.
- rst_n pulled low at RUN cycle 5 of CLZ 0x0000_00FF → busy, done, count and o_norm read 0 immediately (asynchronous); no done pulse. After release, CLZ 0x0000_00FF → count=24, o_norm=0xFF00_0000.
